// File: rtl/oh_skidbuf_pkg.sv
// rtl/oh_skidbuf_pkg.sv - shared state encodings for valid/ready pipe stages
package oh_skidbuf_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } pipe_state_e;

endpackage

// File: rtl/oh_skidbuf_buffer4.sv
// rtl/oh_skidbuf_buffer4.sv - output buffer-cell stage, behavioural or per-bit cells
module oh_buffer4 #(
  parameter int N    = 1,
  parameter     SYN  = "TRUE",
  parameter     TYPE = "DEFAULT"
) (
  input  logic [N-1:0] in,
  output logic [N-1:0] out
);

  if (SYN == "TRUE") begin : g_behav
    assign out = in;
  end else begin : g_cells
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (TYPE == "INV2") begin : g_inv2
        // inverting cell pair keeps the net polarity while isolating the load
        logic mid;
        assign mid    = ~in[i];
        assign out[i] = ~mid;
      end else begin : g_buf
        assign out[i] = in[i];
      end
    end
  end

endmodule

// File: rtl/oh_skidbuf.sv
// rtl/oh_skidbuf.sv - two-entry valid/ready skid stage with registered in_ready
module oh_skidbuf
  import oh_skidbuf_pkg::*;
#(
  parameter int N    = 32,
  parameter     SYN  = "TRUE",
  parameter     TYPE = "DEFAULT"
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   fill
);

  pipe_state_e state_q, state_d;
  logic [N-1:0] main_q, main_d;
  logic [N-1:0] skid_q, skid_d;
  logic         in_ready_q;
  logic         valid_int;
  logic         in_fire;
  logic         out_fire;

  assign valid_int = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = valid_int & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // flush wins over any simultaneous transfer; the popped word already left
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign in_ready = in_ready_q;
  assign fill     = state_q;

  oh_buffer4 #(
    .N    (N + 1),
    .SYN  (SYN),
    .TYPE (TYPE)
  ) u_obuf (
    .in  ({valid_int, main_q}),
    .out ({out_valid, out_data})
  );

endmodule

// File: tb/tb_oh_skidbuf.sv
// tb/tb_oh_skidbuf.sv - scoreboard bench for oh_skidbuf
module tb_oh_skidbuf;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         nreset;
  logic         flush;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;
  logic [1:0]   fill;

  int tests = 0;
  int fails = 0;
  int pushed = 0;
  logic [N-1:0] sb_q[$];
  logic         stall_prev = 1'b0;
  logic [N-1:0] stall_data = '0;

  oh_skidbuf #(.N(N), .SYN("TRUE"), .TYPE("DEFAULT")) dut (
    .clk       (clk),
    .nreset    (nreset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .fill      (fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // evaluate the cycle at negedge, then advance past the next posedge
  task automatic cycle();
    logic [N-1:0] exp;
    @(negedge clk);
    if (nreset) begin
      if (stall_prev) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_data", {32'd0, out_data}, {32'd0, stall_data});
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("pop_empty_sb", 64'd0, 64'd1);
        end else begin
          exp = sb_q.pop_front();
          chk("out_data", {32'd0, out_data}, {32'd0, exp});
        end
      end
      if (in_valid && in_ready && !flush) begin
        sb_q.push_back(in_data);
        pushed++;
      end
      if (flush) sb_q.delete();
      stall_prev = out_valid && !out_ready && !flush;
      stall_data = out_data;
    end else begin
      sb_q.delete();
      stall_prev = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    nreset    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b1;

    // reset held three cycles with in_valid high
    repeat (3) cycle();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_fill", {62'd0, fill}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    nreset   = 1'b1;
    in_valid = 1'b0;
    cycle();
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

    // back-to-back streaming
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      cycle();
      chk("stream_fill", {62'd0, fill}, 64'd1);
      chk("stream_data", {32'd0, out_data}, i);
    end
    in_valid = 1'b0;
    cycle();
    chk("stream_drain", {62'd0, fill}, 64'd0);

    // skid: stall once 0xA is presented
    in_valid = 1'b1; in_data = 32'hA;
    cycle();
    out_ready = 1'b0; in_data = 32'hB;
    cycle();
    chk("skid_fill", {62'd0, fill}, 64'd2);
    chk("skid_in_ready", {63'd0, in_ready}, 64'd0);
    chk("skid_data", {32'd0, out_data}, 64'hA);
    in_valid = 1'b0;
    cycle();
    chk("skid_hold", {32'd0, out_data}, 64'hA);
    out_ready = 1'b1;
    cycle();
    chk("skid_fill1", {62'd0, fill}, 64'd1);
    chk("skid_data_b", {32'd0, out_data}, 64'hB);
    cycle();
    chk("skid_fill0", {62'd0, fill}, 64'd0);

    // flush while full with in_valid and out_ready high
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hC;
    cycle();
    in_data = 32'hD;
    cycle();
    chk("pre_flush_fill", {62'd0, fill}, 64'd2);
    flush = 1'b1; out_ready = 1'b1; in_data = 32'hEE;
    cycle();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_fill", {62'd0, fill}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    flush = 1'b0; in_data = 32'h55;
    cycle();
    chk("post_flush_data", {32'd0, out_data}, 64'h55);
    in_valid = 1'b0;
    cycle();

    // reset mid-operation at fill=2
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h61;
    cycle();
    in_data = 32'h62;
    cycle();
    chk("pre_rst_fill", {62'd0, fill}, 64'd2);
    nreset = 1'b0; in_valid = 1'b0;
    cycle();
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_data", {32'd0, out_data}, 64'd0);
    chk("mid_rst_fill", {62'd0, fill}, 64'd0);
    nreset = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b1; in_data = 32'h77;
    cycle();
    chk("post_rst_data", {32'd0, out_data}, 64'h77);
    in_valid = 1'b0;
    cycle();

    // random backpressure, 1000 words
    pushed = 0;
    for (int c = 0; c < 20000; c++) begin
      if (pushed >= 1000 && sb_q.size() == 0 && !out_valid) break;
      in_valid  = (pushed < 1000) && ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    in_valid = 1'b0;
    chk("rand_pushed", pushed, 64'd1000);
    chk("rand_sb_empty", sb_q.size(), 64'd0);
    chk("rand_fill", {62'd0, fill}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
